// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Immediate format encodings, select width and XLEN legality check.
package imm_pkg;

  localparam int IMM_W = 4;

  localparam logic [63:0] ZERO = 64'd0;

  typedef enum logic [IMM_W-1:0] {
    IMM_X   = 4'd0,
    IMM_I   = 4'd1,
    IMM_S   = 4'd2,
    IMM_B   = 4'd3,
    IMM_U   = 4'd4,
    IMM_J   = 4'd5,
    IMM_Z   = 4'd6,
    IMM_CI  = 4'd7,
    IMM_CJ  = 4'd8,
    IMM_CB  = 4'd9,
    IMM_CIW = 4'd10,
    IMM_CL  = 4'd11
  } imm_type_t;

  function automatic bit xlen_ok(input int x);
    return (x == 32) || (x == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate field extraction and extension to XLEN.
// Every format fits in 32 bits, so a single bit-31 extension suffices.
module imm_extract #(
  parameter int XLEN  = 32,
  parameter int IMM_W = imm_pkg::IMM_W
) (
  input  logic [31:0]      instr,
  input  logic [IMM_W-1:0] imm_type,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);
  import imm_pkg::*;

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_extract: XLEN must be 32 or 64");
  end
  if (IMM_W < 4) begin : g_bad_immw
    $error("imm_extract: IMM_W must be at least 4");
  end

  logic [3:0]       w_sel;
  logic             w_hi_ok;
  logic [31:0]      w_imm32;
  logic             w_ill;
  logic             w_s;
  logic             w_c;

  assign w_sel   = imm_type[3:0];
  assign w_hi_ok = (imm_type == IMM_W'(imm_type[3:0]));
  assign w_s     = instr[31];
  assign w_c     = instr[12];

  // Select the 32-bit extended immediate for the requested format.
  always_comb begin
    w_imm32 = ZERO[31:0];
    w_ill   = 1'b0;
    case (w_sel)
      IMM_X:   w_imm32 = ZERO[31:0];
      IMM_I:   w_imm32 = {{20{w_s}}, instr[31:20]};
      IMM_S:   w_imm32 = {{20{w_s}}, instr[31:25], instr[11:7]};
      IMM_B:   w_imm32 = {{19{w_s}}, w_s, instr[7],
                          instr[30:25], instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{w_s}}, w_s, instr[19:12],
                          instr[20], instr[30:21], 1'b0};
      IMM_Z:   w_imm32 = {27'b0, instr[19:15]};
      IMM_CI:  w_imm32 = {{26{w_c}}, w_c, instr[6:2]};
      IMM_CJ:  w_imm32 = {{20{w_c}}, w_c, instr[8], instr[10:9],
                          instr[6], instr[7], instr[2], instr[11],
                          instr[5:3], 1'b0};
      IMM_CB:  w_imm32 = {{23{w_c}}, w_c, instr[6:5], instr[2],
                          instr[11:10], instr[4:3], 1'b0};
      IMM_CIW: w_imm32 = {22'b0, instr[10:7], instr[12:11],
                          instr[5], instr[6], 2'b0};
      IMM_CL:  w_imm32 = {25'b0, instr[5], instr[12:10],
                          instr[6], 2'b0};
      default: w_ill   = 1'b1;
    endcase
    if (!w_hi_ok) begin
      w_imm32 = ZERO[31:0];
      w_ill   = 1'b1;
    end
  end

  assign illegal = w_ill;

  if (XLEN == 32) begin : g_x32
    assign imm = w_imm32;
  end else begin : g_x64
    assign imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer.
// in_ready comes straight from the skid flop; skid drains first.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int IMM_W = imm_pkg::IMM_W,
  parameter int TAG_W = 32
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [IMM_W-1:0] in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  import imm_pkg::*;

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_acc;
  logic             w_load;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_ill;
  logic             r_skid_full;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_ill;

  imm_extract #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W)
  ) u_extract (
    .instr    (in_instr),
    .imm_type (in_imm_type),
    .imm      (w_imm),
    .illegal  (w_ill)
  );

  assign w_acc  = in_valid && !r_skid_full;
  assign w_load = !r_out_valid || out_ready;

  // Output register and skid buffer; skid refills output before new input.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= ZERO[XLEN-1:0];
      r_out_tag   <= '0;
      r_out_ill   <= 1'b0;
      r_skid_full <= 1'b0;
      r_skid_imm  <= ZERO[XLEN-1:0];
      r_skid_tag  <= '0;
      r_skid_ill  <= 1'b0;
    end else if (w_load) begin
      if (r_skid_full) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= r_skid_imm;
        r_out_tag   <= r_skid_tag;
        r_out_ill   <= r_skid_ill;
        r_skid_full <= 1'b0;
      end else if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= w_imm;
        r_out_tag   <= in_tag;
        r_out_ill   <= w_ill;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid_full <= 1'b1;
      r_skid_imm  <= w_imm;
      r_skid_tag  <= in_tag;
      r_skid_ill  <= w_ill;
    end
  end

  assign in_ready    = !r_skid_full;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_out_imm;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table, stall, stream, reset.
// Expected values are hand-computed constants and simple counters.
module tb_imm_gen_pipe;

  logic        clock = 1'b0;
  logic        n_reset = 1'b0;

  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_tag, out_tag, out_imm;
  logic [3:0]  in_imm_type;

  logic        c2_in_valid, c2_in_ready, c2_out_valid;
  logic        c2_out_ready, c2_out_illegal;
  logic [31:0] c2_in_instr, c2_in_tag, c2_out_tag;
  logic [63:0] c2_out_imm;
  logic [3:0]  c2_in_imm_type;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  typ;
    logic [63:0] exp;
    logic        ill;
  } vec_t;

  vec_t vt[16];
  vec_t v64[3];

  int n_pass  = 0;
  int n_total = 0;

  int sent, rcvd, cyc, errs;
  logic fi, fo;

  imm_gen_pipe #(.XLEN(32), .IMM_W(4), .TAG_W(32)) dut (
    .clock       (clock),
    .n_reset     (n_reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_imm_type (in_imm_type),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .IMM_W(4), .TAG_W(32)) dut64 (
    .clock       (clock),
    .n_reset     (n_reset),
    .in_valid    (c2_in_valid),
    .in_ready    (c2_in_ready),
    .in_instr    (c2_in_instr),
    .in_imm_type (c2_in_imm_type),
    .in_tag      (c2_in_tag),
    .out_valid   (c2_out_valid),
    .out_ready   (c2_out_ready),
    .out_imm     (c2_out_imm),
    .out_tag     (c2_out_tag),
    .out_illegal (c2_out_illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_vec(input int k);
    chk($sformatf("v%0d_valid", k), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d_imm", k), 64'(out_imm), vt[k].exp);
    chk($sformatf("v%0d_tag", k), 64'(out_tag), 64'(32'h100 + k));
    chk($sformatf("v%0d_ill", k), 64'(out_illegal), 64'(vt[k].ill));
  endtask

  task automatic chk_v64(input int k);
    chk($sformatf("x64_%0d_valid", k), 64'(c2_out_valid), 64'd1);
    chk($sformatf("x64_%0d_imm", k), c2_out_imm, v64[k].exp);
    chk($sformatf("x64_%0d_tag", k), 64'(c2_out_tag),
        64'(32'h200 + k));
  endtask

  initial begin
    vt[0]  = '{32'hFFF00093, 4'd1,  64'hFFFFFFFF, 1'b0};
    vt[1]  = '{32'hFE20AE23, 4'd2,  64'hFFFFFFFC, 1'b0};
    vt[2]  = '{32'h12345037, 4'd4,  64'h12345000, 1'b0};
    vt[3]  = '{32'h0000BFFD, 4'd8,  64'hFFFFFFFE, 1'b0};
    vt[4]  = '{32'h0000BFFD, 4'd13, 64'h0,        1'b1};
    vt[5]  = '{32'hFFFFFFFF, 4'd0,  64'h0,        1'b0};
    vt[6]  = '{32'h80000063, 4'd3,  64'hFFFFF000, 1'b0};
    vt[7]  = '{32'h800000EF, 4'd5,  64'hFFF00000, 1'b0};
    vt[8]  = '{32'h000F8073, 4'd6,  64'h1F,       1'b0};
    vt[9]  = '{32'h00000044, 4'd7,  64'h11,       1'b0};
    vt[10] = '{32'h00001000, 4'd9,  64'hFFFFFF00, 1'b0};
    vt[11] = '{32'h00001FE0, 4'd10, 64'h3FC,      1'b0};
    vt[12] = '{32'h00001C60, 4'd11, 64'h7C,       1'b0};
    vt[13] = '{32'h00000004, 4'd8,  64'h20,       1'b0};
    vt[14] = '{32'hFFFFFFFF, 4'd15, 64'h0,        1'b1};
    vt[15] = '{32'h7FF00013, 4'd1,  64'h7FF,      1'b0};

    v64[0] = '{32'h80000037, 4'd4, 64'hFFFFFFFF80000000, 1'b0};
    v64[1] = '{32'hFFF00093, 4'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    v64[2] = '{32'h12345037, 4'd4, 64'h0000000012345000, 1'b0};

    in_valid = 0; in_instr = 0; in_imm_type = 0;
    in_tag = 0; out_ready = 1;
    c2_in_valid = 0; c2_in_instr = 0; c2_in_imm_type = 0;
    c2_in_tag = 0; c2_out_ready = 1;

    // reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_ill", 64'(out_illegal), 64'd0);
    @(negedge clock);
    n_reset = 1;

    // decode table, back to back
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (i > 0) chk_vec(i - 1);
      in_valid    = 1;
      in_instr    = vt[i].instr;
      in_imm_type = vt[i].typ;
      in_tag      = 32'h100 + i;
    end
    @(negedge clock);
    chk_vec(15);
    in_valid = 0;

    // XLEN=64 instance
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i > 0) chk_v64(i - 1);
      c2_in_valid    = 1;
      c2_in_instr    = v64[i].instr;
      c2_in_imm_type = v64[i].typ;
      c2_in_tag      = 32'h200 + i;
    end
    @(negedge clock);
    chk_v64(2);
    c2_in_valid = 0;
    @(negedge clock);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // backpressure: 4 items, out_ready low for 3 cycles
    sent = 0; rcvd = 0; errs = 0;
    for (int c = 0; c < 30 && rcvd < 4; c++) begin
      @(negedge clock);
      in_valid    = (sent < 4);
      in_instr    = {12'(3 * (sent + 1)), 20'h00093};
      in_imm_type = 4'd1;
      in_tag      = sent + 1;
      out_ready   = (c >= 3);
      if (c == 2) begin
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_accepts", 64'(sent), 64'd2);
      end
      if (c == 1 || c == 2) begin
        chk($sformatf("bp_stall_tag_c%0d", c), 64'(out_tag), 64'd1);
        chk($sformatf("bp_stall_imm_c%0d", c), 64'(out_imm), 64'd3);
        chk($sformatf("bp_stall_vld_c%0d", c),
            64'(out_valid), 64'd1);
      end
      fi = in_valid && in_ready;
      fo = out_valid && out_ready;
      if (fo) begin
        chk($sformatf("bp_order_%0d", rcvd + 1),
            64'(out_tag), 64'(rcvd + 1));
        chk($sformatf("bp_imm_%0d", rcvd + 1),
            64'(out_imm), 64'(3 * (rcvd + 1)));
      end
      @(posedge clock);
      if (fi) sent++;
      if (fo) rcvd++;
    end
    chk("bp_sent", 64'(sent), 64'd4);
    chk("bp_rcvd", 64'(rcvd), 64'd4);
    @(negedge clock);
    in_valid = 0;
    out_ready = 1;
    @(negedge clock);

    // throughput: 100 items with out_ready held high
    sent = 0; rcvd = 0; cyc = 0; errs = 0;
    while (rcvd < 100 && cyc < 300) begin
      @(negedge clock);
      in_valid    = (sent < 100);
      in_instr    = {12'(sent + 1), 20'h00093};
      in_imm_type = 4'd1;
      in_tag      = sent + 1;
      out_ready   = 1;
      if (sent < 100 && !in_ready) errs++;
      fi = in_valid && in_ready;
      fo = out_valid && out_ready;
      if (fo && (out_tag != 32'(rcvd + 1))) errs++;
      if (fo && (out_imm != 32'(rcvd + 1))) errs++;
      @(posedge clock);
      cyc++;
      if (fi) sent++;
      if (fo) rcvd++;
    end
    chk("tp_rcvd", 64'(rcvd), 64'd100);
    chk("tp_cycles", 64'(cyc), 64'd101);
    chk("tp_errors", 64'(errs), 64'd0);
    @(negedge clock);
    in_valid = 0;

    // reset with skid full
    @(negedge clock);
    out_ready   = 0;
    in_valid    = 1;
    in_instr    = 32'h00A00093;
    in_imm_type = 4'd1;
    in_tag      = 32'hA1;
    @(negedge clock);
    in_tag = 32'hA2;
    @(negedge clock);
    in_valid = 0;
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2 n_reset = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_imm", 64'(out_imm), 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    chk("arst_out_ill", 64'(out_illegal), 64'd0);
    @(negedge clock);
    n_reset = 1;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    in_valid    = 1;
    in_instr    = 32'h00500093;
    in_imm_type = 4'd1;
    in_tag      = 32'h55;
    out_ready   = 1;
    @(negedge clock);
    in_valid = 0;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_tag", 64'(out_tag), 64'h55);
    chk("post_rst_imm", 64'(out_imm), 64'd5);
    @(negedge clock);
    chk("post_rst_drain", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised successor to the combinational immediate generator.
- Decodes RV32I/RV64I immediates, including CSR zimm, plus a subset of RVC compressed immediates. Sign- or zero-extends each to XLEN.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so decode can run one stage ahead of execute without throughput loss.
- Carries a tag (PC or micro-op ID) alongside each result and flags unsupported immediate types.

Parameters:
- XLEN, 32: datapath width. Only 32 or 64 are legal; any other value is an elaboration error.
- IMM_W, 4: width of the imm_type select.
- TAG_W, 32: width of the pass-through tag.

Ports:
- clock  in  1  system clock, rising edge
- n_reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  block can accept the instruction this cycle
- in_instr  in  32  raw instruction; RVC forms in bits [15:0]
- in_imm_type  in  IMM_W  immediate format select
- in_tag  in  TAG_W  sideband carried with the instruction
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_imm  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag of the result
- out_illegal  out  1  imm_type not in the encoding list; out_imm is 0

Behaviour:
- Encodings (imm_type_t): X=0, I=1, S=2, B=3, U=4, J=5, Z=6, CI=7, CJ=8, CB=9, CIW=10, CL=11. Values 12-15 are illegal.
- X: imm = 0, out_illegal = 0.
- I, S, B, J: standard RV field mapping, sign-extended from instr[31] to XLEN.
- U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
- Z: zero-extend instr[19:15].
- CI: sext{instr[12], instr[6:2]}.
- CJ: sext{instr[12], instr[8], instr[10:9], instr[6], instr[7], instr[2], instr[11], instr[5:3], 1'b0}.
- CB: sext{instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0}.
- CIW: zext{instr[10:7], instr[12:11], instr[5], instr[6], 2'b0}.
- CL: zext{instr[5], instr[12:10], instr[6], 2'b0}.
- Illegal type: imm = 0, out_illegal = 1.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Latency is 1 cycle: an instruction accepted at edge N is presented at edge N+1 if the output register is free.
  - Storage is a main output register plus one skid register.
  - in_ready = !skid_full. It is driven directly from a flop, with no combinational path from out_ready.
- Output register is empty, or drains this cycle (out_ready = 1): the accepted item, or the skid item if present, loads into the output register. The skid item always has priority over new input, preserving order.
- Output register is full and out_ready = 0: the accepted item goes to skid, and in_ready falls next cycle.
- Simultaneous drain and accept with skid full: skid moves to output. No accept is possible because in_ready = 0.
- out_valid, out_imm, out_tag and out_illegal stay stable while out_valid && !out_ready.
- Sustained throughput is 1 item per cycle when out_ready is held at 1.
- Reset, asserted any time: out_valid = 0, skid_full = 0, in_ready = 1, out_imm = 0, out_tag = 0, out_illegal = 0. Any in-flight items are discarded. Operation resumes on the first edge after deassertion.
- No X-propagation: datapath registers load only on a transfer.

Decomposition:
- Package imm_pkg holds:
  - the imm_type_t enum with the values above;
  - the IMM_W constant;
  - the ZERO constant;
  - a function that checks legal XLEN.
- Sub-module imm_extract (combinational): instr and imm_type in; imm and illegal out; XLEN parameter.
- imm_gen_pipe instantiates imm_extract on the input side and implements the output register, skid buffer and control.

Test Plan:
- I-type, XLEN=32: 0xFFF00093, type I, out_ready = 1 -> next cycle out_imm = 0xFFFFFFFF, tag echoed, out_illegal = 0.
- S-type and U-type:
  - 0xFE20AE23, type S -> 0xFFFFFFFC.
  - 0x12345037, type U -> 0x12345000.
  - XLEN=64, 0x80000037, type U -> 0xFFFFFFFF80000000.
- RVC: 0x0000BFFD, type CJ -> 0xFFFFFFFE. Type 13 -> out_imm = 0, out_illegal = 1.
- Backpressure: stream 4 tagged items (tags 1-4) with out_ready = 0 for 3 cycles.
  - in_ready drops after 2 accepts.
  - Items then emerge in order 1, 2, 3, 4 with no loss or duplication.
  - Outputs stay stable while stalled.
- Throughput: out_ready held at 1 for 100 back-to-back items -> 100 results in 101 cycles.
- Reset mid-operation: pull n_reset low with the skid full -> out_valid = 0 and in_ready = 1 immediately (asynchronous). After release, the first new item appears 1 cycle after acceptance.
